// File: rtl/d_e_pipe_reg_if.sv
// d_e_pipe_reg_if: D->E pipeline bundle; master drives the D-stage side, slave (the pipe register) drives the E side.
interface d_e_pipe_reg_if #(
  parameter int EXC_W = 5
);
  logic             Req;
  logic             stall;
  logic [31:0]      D_PC;
  logic [31:0]      D_Instr;
  logic [31:0]      D_RD1;
  logic [31:0]      D_RD2;
  logic [31:0]      D_EXT;
  logic [EXC_W-1:0] D_ExcCode;
  logic             D_BD;
  logic [2:0]       D_MDUOp;
  logic             D_MDUStart;
  logic             D_MDUUse;
  logic             E_Busy;
  logic [31:0]      E_PC;
  logic [31:0]      E_Instr;
  logic [31:0]      E_RD1;
  logic [31:0]      E_RD2;
  logic [31:0]      E_EXT;
  logic [EXC_W-1:0] E_ExcCode;
  logic             E_BD;
  logic [2:0]       E_MDUOp;
  logic             E_MDUStart;
  logic             mdu_stall;
  modport master (
    output Req, stall, D_PC, D_Instr, D_RD1, D_RD2, D_EXT, D_ExcCode, D_BD,
           D_MDUOp, D_MDUStart, D_MDUUse, E_Busy,
    input  E_PC, E_Instr, E_RD1, E_RD2, E_EXT, E_ExcCode, E_BD, E_MDUOp,
           E_MDUStart, mdu_stall
  );
  modport slave (
    input  Req, stall, D_PC, D_Instr, D_RD1, D_RD2, D_EXT, D_ExcCode, D_BD,
           D_MDUOp, D_MDUStart, D_MDUUse, E_Busy,
    output E_PC, E_Instr, E_RD1, E_RD2, E_EXT, E_ExcCode, E_BD, E_MDUOp,
           E_MDUStart, mdu_stall
  );
endinterface

// File: rtl/d_e_pipe_reg.sv
// d_e_pipe_reg: Decode->Execute pipeline register with flush/bubble handling and MDU start/stall logic.
// Ports: clk, reset (async, active-high), bus (slave side of d_e_pipe_reg_if: D-stage inputs, Req, stall,
// E_Busy in; E-stage registered fields, E_MDUStart pulse and combinational mdu_stall out).
module d_e_pipe_reg #(
  parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
  parameter int          EXC_W     = 5
) (
  input logic           clk,
  input logic           reset,
  d_e_pipe_reg_if.slave bus
);
  // Registered E_MDUStart counts as busy: it covers the cycle the MDU accepts Start before Busy rises.
  assign bus.mdu_stall = bus.D_MDUUse & (bus.E_Busy | bus.E_MDUStart);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.E_PC       <= '0;
      bus.E_Instr    <= '0;
      bus.E_RD1      <= '0;
      bus.E_RD2      <= '0;
      bus.E_EXT      <= '0;
      bus.E_ExcCode  <= '0;
      bus.E_BD       <= 1'b0;
      bus.E_MDUOp    <= '0;
      bus.E_MDUStart <= 1'b0;
    end else begin
      // Flush points E at the handler; a bubble keeps PC/BD so a later exception reports the right EPC/BD.
      bus.E_PC       <= bus.Req ? EXC_ENTRY : bus.D_PC;
      bus.E_BD       <= !bus.Req && bus.D_BD;
      bus.E_Instr    <= (bus.Req || bus.stall) ? '0 : bus.D_Instr;
      bus.E_RD1      <= (bus.Req || bus.stall) ? '0 : bus.D_RD1;
      bus.E_RD2      <= (bus.Req || bus.stall) ? '0 : bus.D_RD2;
      bus.E_EXT      <= (bus.Req || bus.stall) ? '0 : bus.D_EXT;
      bus.E_ExcCode  <= (bus.Req || bus.stall) ? '0 : bus.D_ExcCode;
      bus.E_MDUOp    <= (bus.Req || bus.stall) ? '0 : bus.D_MDUOp;
      // A faulted instruction never starts the MDU; E never holds, so this is a one-cycle pulse.
      bus.E_MDUStart <= !bus.Req && !bus.stall && bus.D_MDUStart && (bus.D_ExcCode == '0);
    end
  end
endmodule

// File: tb/tb_d_e_pipe_reg.sv
// tb_d_e_pipe_reg: directed self-checking bench for d_e_pipe_reg.
module tb_d_e_pipe_reg;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_checks = 0;
  int n_fail = 0;
  d_e_pipe_reg_if bus ();
  d_e_pipe_reg dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic drive(input logic [31:0] pc, input logic [31:0] instr, input logic [4:0] exc,
                       input logic bd, input logic [2:0] op, input logic start, input logic use_);
    bus.D_PC = pc;
    bus.D_Instr = instr;
    bus.D_RD1 = 32'h1111_1111;
    bus.D_RD2 = 32'h2222_2222;
    bus.D_EXT = 32'h3333_3333;
    bus.D_ExcCode = exc;
    bus.D_BD = bd;
    bus.D_MDUOp = op;
    bus.D_MDUStart = start;
    bus.D_MDUUse = use_;
  endtask
  initial begin
    bus.Req = 1'b0;
    bus.stall = 1'b0;
    bus.E_Busy = 1'b0;
    drive(32'h0, 32'h0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    tick();
    check("reset_pc", bus.E_PC, 32'h0);
    check("reset_start", {31'b0, bus.E_MDUStart}, 32'h0);
    reset = 1'b0;
    drive(32'h3004, 32'h0085_1018, 5'd0, 1'b0, 3'd1, 1'b1, 1'b1);
    tick();
    check("mult_pc", bus.E_PC, 32'h3004);
    check("mult_instr", bus.E_Instr, 32'h0085_1018);
    check("mult_rd1", bus.E_RD1, 32'h1111_1111);
    check("mult_rd2", bus.E_RD2, 32'h2222_2222);
    check("mult_ext", bus.E_EXT, 32'h3333_3333);
    check("mult_op", {29'b0, bus.E_MDUOp}, 32'd1);
    check("mult_start", {31'b0, bus.E_MDUStart}, 32'd1);
    check("mult_stall_pulse", {31'b0, bus.mdu_stall}, 32'd1);
    drive(32'h3008, 32'h0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    tick();
    check("pulse_end_start", {31'b0, bus.E_MDUStart}, 32'd0);
    check("pulse_end_pc", bus.E_PC, 32'h3008);
    drive(32'h3004, 32'h0085_1018, 5'd10, 1'b0, 3'd1, 1'b1, 1'b1);
    tick();
    check("exc_code", {27'b0, bus.E_ExcCode}, 32'd10);
    check("exc_start", {31'b0, bus.E_MDUStart}, 32'd0);
    check("exc_pc", bus.E_PC, 32'h3004);
    reset = 1'b1;
    #1;
    check("async_pc", bus.E_PC, 32'h0);
    check("async_instr", bus.E_Instr, 32'h0);
    check("async_exc", {27'b0, bus.E_ExcCode}, 32'd0);
    check("async_op", {29'b0, bus.E_MDUOp}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    bus.stall = 1'b1;
    drive(32'h3010, 32'h0085_1018, 5'd0, 1'b1, 3'd1, 1'b1, 1'b0);
    tick();
    check("bubble_pc", bus.E_PC, 32'h3010);
    check("bubble_bd", {31'b0, bus.E_BD}, 32'd1);
    check("bubble_instr", bus.E_Instr, 32'h0);
    check("bubble_op", {29'b0, bus.E_MDUOp}, 32'd0);
    check("bubble_start", {31'b0, bus.E_MDUStart}, 32'd0);
    check("bubble_rd1", bus.E_RD1, 32'h0);
    bus.Req = 1'b1;
    drive(32'h3020, 32'h0085_1018, 5'd4, 1'b1, 3'd1, 1'b1, 1'b0);
    tick();
    check("flush_pc", bus.E_PC, 32'h0000_4180);
    check("flush_bd", {31'b0, bus.E_BD}, 32'd0);
    check("flush_instr", bus.E_Instr, 32'h0);
    check("flush_exc", {27'b0, bus.E_ExcCode}, 32'd0);
    check("flush_start", {31'b0, bus.E_MDUStart}, 32'd0);
    check("flush_ext", bus.E_EXT, 32'h0);
    bus.Req = 1'b0;
    bus.stall = 1'b0;
    drive(32'h3030, 32'h0085_1018, 5'd0, 1'b0, 3'd1, 1'b1, 1'b0);
    tick();
    drive(32'h3034, 32'h0000_1012, 5'd0, 1'b0, 3'd0, 1'b0, 1'b1);
    #1;
    check("mflo_vs_start", {31'b0, bus.mdu_stall}, 32'd1);
    tick();
    bus.E_Busy = 1'b1;
    #1;
    check("mflo_vs_busy", {31'b0, bus.mdu_stall}, 32'd1);
    bus.E_Busy = 1'b0;
    #1;
    check("mflo_idle", {31'b0, bus.mdu_stall}, 32'd0);
    bus.D_MDUUse = 1'b0;
    bus.E_Busy = 1'b1;
    #1;
    check("nonmdu_busy", {31'b0, bus.mdu_stall}, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
